// File: rtl/pipe_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply uses a right-shifting shift-add datapath. Divide uses restoring
// shift-subtract. Both run on magnitudes and apply the sign in a final FIX
// cycle. Each operation takes one accept edge, WIDTH step edges and one
// FIX edge.
module pipe_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [WIDTH-1:0]     a_r;        // multiplicand, or dividend shifted out MSB first
    logic [WIDTH-1:0]     b_r;        // multiplier shifted out LSB first, or divisor
    logic [2*WIDTH-1:0]   acc_r;      // product, or {remainder, quotient}
    logic                 is_div_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;
    logic                 div_zero_r;
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 is_signed_s;
    logic                 is_div_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_trial_s;
    logic [WIDTH:0]       div_diff_s;
    logic                 div_ge_s;
    logic [2*WIDTH-1:0]   step_acc_s;
    logic [2*WIDTH-1:0]   mul_prod_s;
    logic [WIDTH-1:0]     fix_hi_s;
    logic [WIDTH-1:0]     fix_lo_s;

    // Two's-complement negation of one operand-width word.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a full double-width product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand. Unsigned ops pass the raw value through.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    // Decode the signedness and kind of the requested operation.
    always_comb begin
        is_signed_s = 1'b0;
        is_div_s    = 1'b0;
        case (op)
            OP_MULT:  begin is_signed_s = 1'b1; is_div_s = 1'b0; end
            OP_MULTU: begin is_signed_s = 1'b0; is_div_s = 1'b0; end
            OP_DIV:   begin is_signed_s = 1'b1; is_div_s = 1'b1; end
            OP_DIVU:  begin is_signed_s = 1'b0; is_div_s = 1'b1; end
            default:  begin is_signed_s = 1'b0; is_div_s = 1'b0; end
        endcase
    end

    // One iteration of shift-add or restoring shift-subtract.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (b_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        div_trial_s = {acc_r[2*WIDTH-1:WIDTH], a_r[WIDTH-1]};
        div_diff_s  = div_trial_s - {1'b0, b_r};
        div_ge_s    = ~div_diff_s[WIDTH];
        if (is_div_r) begin
            if (div_ge_s) begin
                step_acc_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_acc_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override of the final result.
    always_comb begin
        mul_prod_s = neg_res_r ? neg_2w(acc_r) : acc_r;
        if (is_div_r) begin
            // With a zero divisor the remainder path yields |a|, and re-signing it restores a.
            fix_hi_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            if (div_zero_r) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_lo_s = neg_res_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            end
        end else begin
            fix_hi_s = mul_prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = mul_prod_s[WIDTH-1:0];
        end
    end

    // Control FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CW{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else if (cancel) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                a_r        <= mag(a, is_signed_s);
                                b_r        <= mag(b, is_signed_s);
                                acc_r      <= {(2*WIDTH){1'b0}};
                                cnt_r      <= {CW{1'b0}};
                                is_div_r   <= is_div_s;
                                neg_res_r  <= is_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem_r  <= is_signed_s & is_div_s & a[WIDTH-1];
                                div_zero_r <= (b == {WIDTH{1'b0}});
                                busy_r     <= 1'b1;
                                state_r    <= S_CALC;
                            end
                            OP_MTHI: hi_r <= a;
                            OP_MTLO: lo_r <= a;
                            default: state_r <= S_IDLE;
                        endcase
                    end
                end
                S_CALC: begin
                    acc_r <= step_acc_s;
                    if (is_div_r) begin
                        a_r <= {a_r[WIDTH-2:0], 1'b0};
                    end else begin
                        b_r <= {1'b0, b_r[WIDTH-1:1]};
                    end
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Directed bench for pipe_muldiv_unit: a 32-bit instance for the main
// operations and an 8-bit instance for the narrow case and mid-op reset.
module tb_pipe_muldiv_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        reset8, start8, cancel8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int errors = 0;
    int checks = 0;
    int ncyc;
    logic early, seen;

    pipe_muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    pipe_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .op(op8), .a(a8), .b(b8),
        .cancel(cancel8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one 32-bit operation, scramble operands, count busy cycles.
    task automatic run32(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D;
        ncyc = 0; early = 1'b0;
        while (busy === 1'b1 && ncyc < 100) begin
            ncyc++;
            if (done !== 1'b0) early = 1'b1;
            tick();
        end
    endtask

    // Run an operation and check timing, done pulse and HI/LO.
    task automatic op32(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
        run32(o, av, bv);
        chk({tag, "_cycles"}, 64'(ncyc), 64'd33);
        chk({tag, "_early_done"}, 64'(early), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        tick();
        chk({tag, "_done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        reset8 = 1'b1; start8 = 1'b0; cancel8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
        tick();
        tick();
        reset = 1'b0; reset8 = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        // Signed multiply -3 * 5 = -15
        op32("mult", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);

        // Divides: unsigned, signed with negative dividend, signed overflow
        op32("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        op32("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        op32("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

        // Divide by zero, unsigned and signed
        op32("divu_z", 3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
        op32("div_z", 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // MTHI / MTLO preload
        op = 3'd4; a = 32'hAA; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hAA);
        chk("mthi_busy", 64'(busy), 64'd0);
        op = 3'd5; a = 32'h55; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h55);
        chk("mtlo_hi", 64'(hi), 64'hAA);
        chk("mtlo_done", 64'(done), 64'd0);

        // Cancel at CALC counter=10
        op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        chk("cancel_busy_on", 64'(busy), 64'd1);
        repeat (10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy_off", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("cancel_no_done", 64'(seen), 64'd0);
        chk("cancel_hi", 64'(hi), 64'hAA);
        chk("cancel_lo", 64'(lo), 64'h55);

        // Cancel together with start: nothing starts
        op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("cs_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("cs_idle", 64'(seen), 64'd0);
        chk("cs_lo", 64'(lo), 64'h55);

        // Start while busy is ignored
        op = 3'd1; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        op = 3'd4; a = 32'h77; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rej_hi", 64'(hi), 64'hAA);
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 100) begin
            ncyc++;
            tick();
        end
        chk("busy_rej_done", 64'(done), 64'd1);
        chk("busy_rej_res", {32'(hi), 32'(lo)}, {32'd0, 32'd6});
        tick();
        op = 3'd5; a = 32'h99; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mtlo2_lo", 64'(lo), 64'h99);
        chk("mtlo2_hi", 64'(hi), 64'd0);
        chk("mtlo2_flags", {62'd0, busy, done}, 64'd0);

        // Cancel in FIX discards the result
        op = 3'd1; a = 32'd4; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        chk("fixc_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("fixc_flags", {62'd0, busy, done}, 64'd0);
        chk("fixc_res", {32'(hi), 32'(lo)}, {32'd0, 32'h99});
        tick();
        chk("fixc_done_late", 64'(done), 64'd0);

        // Narrow instance: MULT 0x80 * 0x80 = 0x4000
        chk("n_rst", {46'd0, busy8, done8, hi8, lo8}, 64'd0);
        op8 = 3'd0; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
        ncyc = 0;
        while (busy8 === 1'b1 && ncyc < 100) begin
            ncyc++;
            tick();
        end
        chk("n_cycles", 64'(ncyc), 64'd9);
        chk("n_done", 64'(done8), 64'd1);
        chk("n_prod", {48'd0, hi8, lo8}, 64'h4000);

        // Reset mid-CALC
        tick();
        op8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        chk("n_midop_busy", 64'(busy8), 64'd1);
        reset8 = 1'b1;
        tick();
        reset8 = 1'b0;
        chk("n_reset", {46'd0, busy8, done8, hi8, lo8}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
